// File: rtl/host_link_pkg.sv
// Shared types and constants for the host link arbiter and its response demux.
package host_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ABORT = 2'd2
   } host_arb_state_t;

   localparam logic HOST_SRC_UART = 1'b0;
   localparam logic HOST_SRC_UDP  = 1'b1;

endpackage

// File: rtl/host_link_rsp_demux.sv
// Routes the command engine's response stream to the UART or UDP link by destination ID.
// Latency: combinational. Backpressure: o_rsp_ready mirrors the selected link's ready.
module host_link_rsp_demux
   import host_link_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_rsp_data,
   input  logic                  i_rsp_valid,
   input  logic                  i_rsp_last,
   input  logic                  i_rsp_dest,
   output logic                  o_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_uart_rsp_data,
   output logic                  o_uart_rsp_valid,
   output logic                  o_uart_rsp_last,
   input  logic                  i_uart_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_udp_rsp_data,
   output logic                  o_udp_rsp_valid,
   output logic                  o_udp_rsp_last,
   input  logic                  i_udp_rsp_ready
);

   logic to_udp;
   assign to_udp = (i_rsp_dest == HOST_SRC_UDP);

   // Data and last fan out to both links; only valid is qualified by the destination.
   assign o_uart_rsp_data  = i_rsp_data;
   assign o_uart_rsp_last  = i_rsp_last;
   assign o_uart_rsp_valid = i_rsp_valid & ~to_udp;

   assign o_udp_rsp_data   = i_rsp_data;
   assign o_udp_rsp_last   = i_rsp_last;
   assign o_udp_rsp_valid  = i_rsp_valid & to_udp;

   assign o_rsp_ready = to_udp ? i_udp_rsp_ready : i_uart_rsp_ready;

endmodule

// File: rtl/host_link_arbiter.sv
// Packet round-robin arbiter merging UART/UDP command streams onto one sink; responses routed by dest ID.
// Latency: 1-cycle arbitration, then combinational pass-through with one IDLE bubble between packets.
// Backpressure: i_cmd_ready reaches the granted link only; HOST_LINK_ARBITER_TIMEOUT_EN adds a stalled-packet abort.
module host_link_arbiter
   import host_link_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_uart_data,
   input  logic                  i_uart_valid,
   input  logic                  i_uart_last,
   output logic                  o_uart_ready,
   input  logic [DATA_WIDTH-1:0] i_udp_data,
   input  logic                  i_udp_valid,
   input  logic                  i_udp_last,
   output logic                  o_udp_ready,
   output logic [DATA_WIDTH-1:0] o_cmd_data,
   output logic                  o_cmd_valid,
   output logic                  o_cmd_last,
   output logic                  o_cmd_source,
   output logic                  o_cmd_abort,
   input  logic                  i_cmd_ready,
   input  logic [DATA_WIDTH-1:0] i_rsp_data,
   input  logic                  i_rsp_valid,
   input  logic                  i_rsp_last,
   input  logic                  i_rsp_dest,
   output logic                  o_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_uart_rsp_data,
   output logic                  o_uart_rsp_valid,
   output logic                  o_uart_rsp_last,
   input  logic                  i_uart_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_udp_rsp_data,
   output logic                  o_udp_rsp_valid,
   output logic                  o_udp_rsp_last,
   input  logic                  i_udp_rsp_ready,
   output logic [15:0]           o_uart_pkt_count,
   output logic [15:0]           o_udp_pkt_count
);

   host_arb_state_t state_q, state_d;
   logic            grant_q, grant_d;
   logic            prio_q, prio_d;
   logic            pkt_done;
   logic [15:0]     uart_cnt_q, udp_cnt_q;

   logic [DATA_WIDTH-1:0] g_dat;
   logic                  g_vld, g_last;

   assign g_dat  = (grant_q == HOST_SRC_UDP) ? i_udp_data  : i_uart_data;
   assign g_vld  = (grant_q == HOST_SRC_UDP) ? i_udp_valid : i_uart_valid;
   assign g_last = (grant_q == HOST_SRC_UDP) ? i_udp_last  : i_uart_last;

`ifdef HOST_LINK_ARBITER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit;

   // The counter reaches TIMEOUT_CYCLES-1 on the same edge that moves the FSM into ABORT.
   assign tmo_hit = !g_vld && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge i_clock) begin
      if (i_reset || state_q != GRANT || (g_vld && i_cmd_ready))
         tmo_q <= '0;
      else if (!g_vld)
         tmo_q <= tmo_q + 1'b1;
   end
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      prio_d       = prio_q;
      pkt_done     = 1'b0;
      o_cmd_data   = '0;
      o_cmd_valid  = 1'b0;
      o_cmd_last   = 1'b0;
      o_cmd_abort  = 1'b0;
      o_uart_ready = 1'b0;
      o_udp_ready  = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_uart_valid || i_udp_valid) begin
               if (i_uart_valid && i_udp_valid)
                  grant_d = prio_q;
               else
                  grant_d = i_udp_valid ? HOST_SRC_UDP : HOST_SRC_UART;
               state_d = GRANT;
            end
         end
         GRANT: begin
            o_cmd_data  = g_dat;
            o_cmd_valid = g_vld;
            o_cmd_last  = g_last;
            if (grant_q == HOST_SRC_UDP)
               o_udp_ready = i_cmd_ready;
            else
               o_uart_ready = i_cmd_ready;

            if (g_vld && i_cmd_ready && g_last) begin
               state_d  = IDLE;
               prio_d   = ~grant_q;
               pkt_done = 1'b1;
            end
`ifdef HOST_LINK_ARBITER_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = ABORT;
            end
`endif
         end
         ABORT: begin
`ifdef HOST_LINK_ARBITER_TIMEOUT_EN
            o_cmd_valid = 1'b1;
            o_cmd_last  = 1'b1;
            o_cmd_abort = 1'b1;
            if (i_cmd_ready) begin
               state_d = IDLE;
               prio_d  = ~grant_q;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= IDLE;
         grant_q <= HOST_SRC_UART;
         prio_q  <= HOST_SRC_UART;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         prio_q  <= prio_d;
      end
   end

   // Only packets closed by a real last-beat handshake are counted; aborts and reset-dropped packets are not.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         uart_cnt_q <= '0;
         udp_cnt_q  <= '0;
      end else if (pkt_done) begin
         if (grant_q == HOST_SRC_UDP)
            udp_cnt_q <= udp_cnt_q + 16'd1;
         else
            uart_cnt_q <= uart_cnt_q + 16'd1;
      end
   end

   assign o_cmd_source     = grant_q;
   assign o_uart_pkt_count = uart_cnt_q;
   assign o_udp_pkt_count  = udp_cnt_q;

   host_link_rsp_demux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_demux (
      .i_rsp_data       (i_rsp_data),
      .i_rsp_valid      (i_rsp_valid),
      .i_rsp_last       (i_rsp_last),
      .i_rsp_dest       (i_rsp_dest),
      .o_rsp_ready      (o_rsp_ready),
      .o_uart_rsp_data  (o_uart_rsp_data),
      .o_uart_rsp_valid (o_uart_rsp_valid),
      .o_uart_rsp_last  (o_uart_rsp_last),
      .i_uart_rsp_ready (i_uart_rsp_ready),
      .o_udp_rsp_data   (o_udp_rsp_data),
      .o_udp_rsp_valid  (o_udp_rsp_valid),
      .o_udp_rsp_last   (o_udp_rsp_last),
      .i_udp_rsp_ready  (i_udp_rsp_ready)
   );

endmodule

// File: tb/tb_host_link_arbiter.sv
// Directed bench for host_link_arbiter: per-source beat scoreboard plus cycle-exact arbitration checks.
module tb_host_link_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] uart_data, udp_data, cmd_data, rsp_data;
   logic          uart_valid, uart_last, uart_ready;
   logic          udp_valid, udp_last, udp_ready;
   logic          cmd_valid, cmd_last, cmd_source, cmd_abort, cmd_ready;
   logic          rsp_valid, rsp_last, rsp_dest, rsp_ready;
   logic [DW-1:0] uart_rsp_data, udp_rsp_data;
   logic          uart_rsp_valid, uart_rsp_last, uart_rsp_ready;
   logic          udp_rsp_valid, udp_rsp_last, udp_rsp_ready;
   logic [15:0]   uart_cnt, udp_cnt;

   host_link_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_uart_data(uart_data), .i_uart_valid(uart_valid), .i_uart_last(uart_last), .o_uart_ready(uart_ready),
      .i_udp_data(udp_data), .i_udp_valid(udp_valid), .i_udp_last(udp_last), .o_udp_ready(udp_ready),
      .o_cmd_data(cmd_data), .o_cmd_valid(cmd_valid), .o_cmd_last(cmd_last),
      .o_cmd_source(cmd_source), .o_cmd_abort(cmd_abort), .i_cmd_ready(cmd_ready),
      .i_rsp_data(rsp_data), .i_rsp_valid(rsp_valid), .i_rsp_last(rsp_last), .i_rsp_dest(rsp_dest),
      .o_rsp_ready(rsp_ready),
      .o_uart_rsp_data(uart_rsp_data), .o_uart_rsp_valid(uart_rsp_valid), .o_uart_rsp_last(uart_rsp_last),
      .i_uart_rsp_ready(uart_rsp_ready),
      .o_udp_rsp_data(udp_rsp_data), .o_udp_rsp_valid(udp_rsp_valid), .o_udp_rsp_last(udp_rsp_last),
      .i_udp_rsp_ready(udp_rsp_ready),
      .o_uart_pkt_count(uart_cnt), .o_udp_pkt_count(udp_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_uart[$];
   logic [8:0] exp_udp[$];
   int         hs_cyc[$];
   logic       hs_src[$];
   int         abort_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sink-side monitor: every accepted beat is matched against the scoreboard of its source.
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         if (cmd_abort) begin
            abort_cyc.push_back(cyc);
            chk("abort_data", 32'(cmd_data), 32'h0);
            chk("abort_last", 32'(cmd_last), 32'h1);
         end else begin
            hs_cyc.push_back(cyc);
            hs_src.push_back(cmd_source);
            if (cmd_source) begin
               if (exp_udp.size() == 0) begin
                  checks++; errors++;
                  $error("FAIL udp_extra_beat: observed data 0x%0h, expected no beat", cmd_data);
               end else
                  chk("udp_beat", 32'({cmd_last, cmd_data}), 32'(exp_udp.pop_front()));
            end else begin
               if (exp_uart.size() == 0) begin
                  checks++; errors++;
                  $error("FAIL uart_extra_beat: observed data 0x%0h, expected no beat", cmd_data);
               end else
                  chk("uart_beat", 32'({cmd_last, cmd_data}), 32'(exp_uart.pop_front()));
            end
         end
      end
   end

   // Drives one beat and returns just after the edge that accepted it.
   task automatic put(input bit src, input logic [7:0] d, input bit l);
      bit ok = 1'b0;
      if (src) begin
         exp_udp.push_back({l, d});
         udp_data = d; udp_last = l; udp_valid = 1'b1;
      end else begin
         exp_uart.push_back({l, d});
         uart_data = d; uart_last = l; uart_valid = 1'b1;
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (src ? udp_ready : uart_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      chk(src ? "udp_accept" : "uart_accept", 32'(ok), 32'h1);
   endtask

   task automatic stop(input bit src);
      if (src) begin udp_valid = 1'b0; udp_last = 1'b0; end
      else begin uart_valid = 1'b0; uart_last = 1'b0; end
   endtask

   task automatic clear_logs();
      hs_cyc.delete(); hs_src.delete(); abort_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit rdy_pat[0:6];

      rst = 1'b1;
      uart_data = '0; uart_valid = 1'b1; uart_last = 1'b0;
      udp_data = '0;  udp_valid = 1'b1;  udp_last = 1'b0;
      cmd_ready = 1'b1;
      rsp_data = 8'h3C; rsp_valid = 1'b1; rsp_last = 1'b1; rsp_dest = 1'b0;
      uart_rsp_ready = 1'b1; udp_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
      chk("rst_cmd_abort", 32'(cmd_abort), 32'h0);
      chk("rst_cmd_source", 32'(cmd_source), 32'h0);
      chk("rst_uart_ready", 32'(uart_ready), 32'h0);
      chk("rst_udp_ready", 32'(udp_ready), 32'h0);
      chk("rst_uart_cnt", 32'(uart_cnt), 32'h0);
      chk("rst_udp_cnt", 32'(udp_cnt), 32'h0);
      chk("rst_uart_rsp_valid", 32'(uart_rsp_valid), 32'h1);
      chk("rst_uart_rsp_data", 32'(uart_rsp_data), 32'h3C);
      chk("rst_udp_rsp_valid", 32'(udp_rsp_valid), 32'h0);
      chk("rst_rsp_ready", 32'(rsp_ready), 32'h1);
      @(posedge clk); #1;
      rst = 1'b0; uart_valid = 1'b0; udp_valid = 1'b0; rsp_valid = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Simultaneous request straight after reset: UART first, bubble, then UDP.
      clear_logs(); n = cyc;
      fork
         begin put(0, 8'h41, 0); put(0, 8'h42, 1); stop(0); end
         begin put(1, 8'h51, 0); put(1, 8'h52, 1); stop(1); end
      join
      chk("rr1_first_src", 32'(hs_src[0]), 32'h0);
      chk("rr1_first_cyc", 32'(hs_cyc[0] - n), 32'd1);
      chk("rr1_second_beat_cyc", 32'(hs_cyc[1] - n), 32'd2);
      chk("rr1_udp_src", 32'(hs_src[2]), 32'h1);
      chk("rr1_udp_cyc_bubble", 32'(hs_cyc[2] - n), 32'd4);
      chk("rr1_uart_cnt", 32'(uart_cnt), 32'd1);
      chk("rr1_udp_cnt", 32'(udp_cnt), 32'd1);

      // UART 3-beat packet, sink always ready.
      clear_logs(); n = cyc;
      put(0, 8'h11, 0); put(0, 8'h22, 0); put(0, 8'h33, 1); stop(0);
      chk("u3_beats", 32'(hs_cyc.size()), 32'd3);
      chk("u3_cyc0", 32'(hs_cyc[0] - n), 32'd1);
      chk("u3_cyc2", 32'(hs_cyc[2] - n), 32'd3);
      chk("u3_src", 32'({hs_src[0], hs_src[1], hs_src[2]}), 32'h0);
      chk("u3_uart_cnt", 32'(uart_cnt), 32'd2);

      // UART was served last, so UDP wins the next tie; single-beat packets.
      clear_logs(); n = cyc;
      fork
         begin put(0, 8'h71, 1); stop(0); end
         begin put(1, 8'h61, 1); stop(1); end
      join
      chk("rr2_first_src", 32'(hs_src[0]), 32'h1);
      chk("rr2_first_cyc", 32'(hs_cyc[0] - n), 32'd1);
      chk("rr2_second_src", 32'(hs_src[1]), 32'h0);
      chk("rr2_second_cyc", 32'(hs_cyc[1] - n), 32'd3);

      // Sink ready toggling during a UDP packet while UART waits.
      clear_logs(); n = cyc;
      rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      fork
         begin put(1, 8'h81, 0); put(1, 8'h82, 0); put(1, 8'h83, 1); stop(1); end
         begin put(0, 8'h91, 1); stop(0); end
         begin
            for (int k = 0; k < 7; k++) begin
               cmd_ready = rdy_pat[k];
               @(negedge clk);
               chk("bp_uart_ready_low", 32'(uart_ready), 32'h0);
               if (k == 2) chk("bp_hold_82", 32'({cmd_valid, cmd_data}), 32'h182);
               if (k == 4) chk("bp_hold_83", 32'({cmd_valid, cmd_data}), 32'h183);
               @(posedge clk); #1;
            end
            cmd_ready = 1'b1;
         end
      join
      chk("bp_beats", 32'(hs_cyc.size()), 32'd4);
      chk("bp_uart_cyc", 32'(hs_cyc[3] - n), 32'd7);
      chk("bp_udp_cnt", 32'(udp_cnt), 32'd3);

      // Response demux.
      rsp_dest = 1'b1; rsp_data = 8'hA5; rsp_valid = 1'b1; rsp_last = 1'b1;
      udp_rsp_ready = 1'b0; uart_rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_udp_valid", 32'(udp_rsp_valid), 32'h1);
      chk("rsp_udp_data", 32'(udp_rsp_data), 32'hA5);
      chk("rsp_udp_last", 32'(udp_rsp_last), 32'h1);
      chk("rsp_ready_blocked", 32'(rsp_ready), 32'h0);
      chk("rsp_uart_valid_off", 32'(uart_rsp_valid), 32'h0);
      udp_rsp_ready = 1'b1; #1;
      chk("rsp_ready_udp", 32'(rsp_ready), 32'h1);
      rsp_dest = 1'b0; uart_rsp_ready = 1'b0; #1;
      chk("rsp_ready_uart", 32'(rsp_ready), 32'h0);
      chk("rsp_uart_valid", 32'(uart_rsp_valid), 32'h1);
      chk("rsp_udp_valid_off", 32'(udp_rsp_valid), 32'h0);
      rsp_valid = 1'b0; uart_rsp_ready = 1'b1;
      @(posedge clk); #1;

      // Counter wrap.
      @(negedge clk);
      force dut.udp_cnt_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.udp_cnt_q;
      @(negedge clk);
      chk("wrap_preset", 32'(udp_cnt), 32'hFFFF);
      @(posedge clk); #1;
      put(1, 8'hE1, 1); stop(1);
      chk("wrap_udp_cnt", 32'(udp_cnt), 32'h0);
      chk("wrap_uart_cnt", 32'(uart_cnt), 32'd4);

      // Reset in the middle of a UART packet.
      put(0, 8'hC1, 0);
      uart_data = 8'hC2;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_cmd_valid", 32'(cmd_valid), 32'h0);
      chk("midrst_uart_ready", 32'(uart_ready), 32'h0);
      chk("midrst_uart_cnt", 32'(uart_cnt), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; stop(0);
      @(posedge clk); #1;

      // UART stalls after its first beat.
      clear_logs(); n = cyc;
      put(0, 8'hD1, 0); stop(0);
`ifdef HOST_LINK_ARBITER_TIMEOUT_EN
      repeat (10) @(posedge clk); #1;
      chk("tmo_abort_count", 32'(abort_cyc.size()), 32'd1);
      chk("tmo_abort_cyc", 32'(abort_cyc[0] - n), 32'd9);
      chk("tmo_uart_cnt", 32'(uart_cnt), 32'h0);
      put(0, 8'hD2, 1); stop(0);
      chk("tmo_newpkt_cnt", 32'(uart_cnt), 32'd1);
`else
      fork
         begin
            repeat (20) @(negedge clk);
            chk("stall_source", 32'(cmd_source), 32'h0);
            chk("stall_udp_ready", 32'(udp_ready), 32'h0);
            chk("stall_cmd_valid", 32'(cmd_valid), 32'h0);
            chk("stall_no_abort", 32'(cmd_abort), 32'h0);
            @(posedge clk); #1;
            put(0, 8'hD2, 1); stop(0);
         end
         begin put(1, 8'hE5, 1); stop(1); end
      join
      chk("stall_order", 32'({hs_src[0], hs_src[1], hs_src[2]}), 32'b001);
      chk("stall_uart_cnt", 32'(uart_cnt), 32'd1);
      chk("stall_udp_cnt", 32'(udp_cnt), 32'd1);
`endif

      repeat (2) @(posedge clk); #1;
      chk("sb_uart_drained", 32'(exp_uart.size()), 32'd0);
      chk("sb_udp_drained", 32'(exp_udp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
